// File: rtl/dds_phase_gen.sv
// DDS phase generator: phase accumulator with a handshaked
// tuning word that is applied only on a phase boundary.
module dds_phase_gen #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 12
) (
  input  logic             Fg_CLK,
  input  logic             RESET,
  input  logic             Enable,
  input  logic [ACC_W-1:0] Ftw_In,
  input  logic             Ftw_Valid,
  output logic             Ftw_Ready,
  input  logic [1:0]       Wave_Sel,
  input  logic             Phase_Sync,
  output logic [OUT_W-1:0] Dac_Data,
  output logic             Wrap
);

  localparam logic [OUT_W-1:0] MID =
    {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_phase;
  logic [ACC_W-1:0] r_ftw;
  logic [ACC_W-1:0] r_shadow;
  logic [OUT_W-1:0] r_dac;
  logic             r_wrap;

  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_xfer;
  logic             w_busy;
  logic             w_bound;
  logic [OUT_W:0]   w_p;
  logic [OUT_W-1:0] w_wave;

  assign w_sum   = {1'b0, r_phase} + {1'b0, r_ftw};
  assign w_carry = w_sum[ACC_W];
  assign w_busy  = (r_state != S_IDLE);
  assign w_xfer  = Ftw_Valid & Ftw_Ready;
  assign w_bound = Phase_Sync | w_carry;
  assign w_p     = r_phase[ACC_W-1 -: OUT_W+1];

  assign Ftw_Ready = (r_state != S_PEND);
  assign Dac_Data  = r_dac;
  assign Wrap      = r_wrap;

  // Next-state logic; dropping Enable always wins
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (Enable) w_next = S_RUN;
      end
      S_RUN: begin
        if (!Enable)     w_next = S_IDLE;
        else if (w_xfer) w_next = S_PEND;
      end
      S_PEND: begin
        if (!Enable)      w_next = S_IDLE;
        else if (w_bound) w_next = S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Waveform shaping from the top OUT_W+1 phase bits
  always_comb begin
    w_wave = MID;
    unique case (Wave_Sel)
      2'd0: w_wave = w_p[OUT_W:1];
      2'd1: w_wave = {OUT_W{w_p[OUT_W]}};
      2'd2: w_wave = w_p[OUT_W] ? ~w_p[OUT_W-1:0]
                                :  w_p[OUT_W-1:0];
      2'd3: w_wave = MID;
    endcase
  end

  // State register
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Phase accumulator; sync clears it ahead of accumulation
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET)
      r_phase <= '0;
    else if (!w_busy || !Enable || Phase_Sync)
      r_phase <= '0;
    else
      r_phase <= w_sum[ACC_W-1:0];
  end

  // Active and shadow tuning words
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      r_ftw    <= '0;
      r_shadow <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_xfer) r_ftw <= Ftw_In;
        end
        S_RUN: begin
          if (!Enable)     r_shadow <= '0;
          else if (w_xfer) r_shadow <= Ftw_In;
        end
        S_PEND: begin
          if (!Enable)      r_shadow <= '0;
          else if (w_bound) r_ftw <= r_shadow;
        end
        default: r_shadow <= '0;
      endcase
    end
  end

  // Overflow pulse, suppressed by sync or disable
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) r_wrap <= 1'b0;
    else       r_wrap <= w_busy & Enable &
                         ~Phase_Sync & w_carry;
  end

  // Output sample: midscale whenever idle on either side
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET)
      r_dac <= MID;
    else if (!w_busy || w_next == S_IDLE)
      r_dac <= MID;
    else
      r_dac <= w_wave;
  end

endmodule
